// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: blank pattern, hex glyph table
// and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low segments A (MSB) .. G (LSB) for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with leading-zero
// blanking and dead time; per-digit blink is compiled in with SEVEN_SEG_BLINK_EN.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned DEAD_CYCLES  = 16
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IW = idx_width(NUM_DIGITS);
  localparam int unsigned PW = idx_width(REFRESH_DIV);
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         val_q, val_d;
  logic [NUM_DIGITS-1:0] dpl_q, dpl_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic                  all_zero;
  logic [6:0]            dec_seg;
  logic                  slot_end;

`ifdef SEVEN_SEG_BLINK_EN
  localparam int unsigned FW = idx_width(BLINK_FRAMES);
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_off_q, phase_off_d;
`endif

  seg7_hex_decode u_dec (
    .nibble_i (nib),
    .seg_c    (dec_seg)
  );

  assign slot_end = (presc_q == PW'(REFRESH_DIV - 1));

  // Scan position, latch and blink phase
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    val_d   = val_q;
    dpl_d   = dpl_q;
`ifdef SEVEN_SEG_BLINK_EN
    frame_d     = frame_q;
    phase_off_d = phase_off_q;
`endif
    if (load) begin
      val_d = value;
      dpl_d = dp_in;
    end
    if (slot_end) begin
      presc_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
`ifdef SEVEN_SEG_BLINK_EN
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_d     = '0;
          phase_off_d = ~phase_off_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
`endif
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Digit select, blanking and anode pattern for the current slot
  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    blank    = 1'b0;
    all_zero = 1'b1;
    an_d     = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = val_q[4*i +: 4];
        dp_sel = dpl_q[i];
        if (presc_q >= PW'(DEAD_CYCLES)) an_d[i] = 1'b0;
      end
    end
    // Walk down from the top digit; a digit blanks only if it and all above are zero
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (val_q[4*i +: 4] != 4'h0) all_zero = 1'b0;
      if ((idx_q == IW'(i)) && all_zero) blank = lz_blank;
    end
`ifdef SEVEN_SEG_BLINK_EN
    an_d = an_d | (blink & {NUM_DIGITS{phase_off_q}});
`endif
    seg_d = blank ? SEG_OFF : dec_seg;
    dp_d  = ~dp_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dpl_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= '1;
`ifdef SEVEN_SEG_BLINK_EN
      frame_q     <= '0;
      phase_off_q <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dpl_q   <= dpl_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
`ifdef SEVEN_SEG_BLINK_EN
      frame_q     <= frame_d;
      phase_off_q <= phase_off_d;
`endif
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: vector table, corner sequences and
// randomized traffic against a cycle-count reference model (blink with SEVEN_SEG_BLINK_EN).
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int DC = 1;
  localparam int BF = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
`ifdef SEVEN_SEG_BLINK_EN
  logic [3:0]  blink;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset, plus latched value/dp
  int          t;
  logic [15:0] lat;
  logic [3:0]  lat_dp;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .DEAD_CYCLES  (DC)
`ifdef SEVEN_SEG_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .lz_blank (lz_blank),
`ifdef SEVEN_SEG_BLINK_EN
    .blink    (blink),
`endif
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (model t=%0d, time=%0t)", name, got, want, t, $time);
    end
  endtask

  // One clock: predict from pre-edge model state and driven inputs, advance, compare
  task automatic step();
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    int         idx;
    int         pos;
    logic [15:0] upper;
    if (rst) begin
      es = 7'b1111111;
      ed = 1'b1;
      ea = 4'b1111;
    end else begin
      pos   = t % RD;
      idx   = (t / RD) % N;
      upper = lat >> (4 * idx);
      ea    = 4'b1111;
      if (pos >= DC) ea[idx] = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
      if (((t / (RD * N)) / BF) % 2 == 1) ea = ea | blink;
`endif
      if (lz_blank && idx > 0 && upper == 16'h0) es = 7'b1111111;
      else es = GLYPH[upper[3:0]];
      ed = ~lat_dp[idx];
    end
    @(posedge clk);
    if (rst) begin
      t      = 0;
      lat    = '0;
      lat_dp = '0;
    end else begin
      t = t + 1;
      if (load) begin
        lat    = value;
        lat_dp = dp_in;
      end
    end
    #1;
    check("seg", 32'(seg), 32'(es));
    check("dp",  32'(dp),  32'(ed));
    check("an",  32'(an),  32'(ea));
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic             lz;
    logic [3:0][6:0]  segs;
    logic [3:0]       dps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [3:0][6:0] seg_got;
    logic [3:0]      dp_got;
    logic [3:0]      seen;
    int              on_cnt [4];

    rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; lz_blank = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    blink = '0;
`endif
    t = 0; lat = '0; lat_dp = '0;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1111};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b1111};
    vecs[2] = '{16'h0005, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
    vecs[4] = '{16'h0305, 4'b0100, 1'b1, {7'b1111111, 7'b0000110, 7'b0000001, 7'b0100100}, 4'b1011};
    vecs[5] = '{16'hBCDE, 4'b1001, 1'b1, {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b0110};

    // Reset release: one dead cycle, then digit 0 showing latched zero
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rel_dead_an", 32'(an), 32'h0000000f);
    step();
    check("rel_d0_an", 32'(an), 32'h0000000e);
    check("rel_d0_seg", 32'(seg), 32'(7'b0000001));

    // Table vectors: per-digit glyph and dp captured while that anode is on
    foreach (vecs[v]) begin
      do_reset();
      value = vecs[v].value; dp_in = vecs[v].dp; lz_blank = vecs[v].lz; load = 1'b1;
      step();
      load = 1'b0;
      seen = '0;
      seg_got = '0;
      dp_got = '0;
      repeat (2 * N * RD) begin
        step();
        for (int d = 0; d < N; d++) begin
          if (an == ~(4'b0001 << d) && !seen[d]) begin
            seen[d]    = 1'b1;
            seg_got[d] = seg;
            dp_got[d]  = dp;
          end
        end
      end
      check($sformatf("vec%0d_seen", v), 32'(seen), 32'h0000000f);
      for (int d = 0; d < N; d++)
        check($sformatf("vec%0d_d%0d_seg", v, d), 32'(seg_got[d]), 32'(vecs[v].segs[d]));
      check($sformatf("vec%0d_dp", v), 32'(dp_got), 32'(vecs[v].dps));
    end

    // Mid-slot load: glyph changes exactly one cycle after the load cycle
    lz_blank = 1'b0; dp_in = '0;
    do_reset();
    value = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    step();
    value = 16'h0007; load = 1'b1;
    step();
    load = 1'b0;
    check("mid_old_seg", 32'(seg), 32'(7'b1001111));
    step();
    check("mid_new_seg", 32'(seg), 32'(7'b0001111));
    check("mid_new_an", 32'(an), 32'h0000000e);

    // Reset during digit 2 with a simultaneous load: reset wins
    do_reset();
    value = 16'hFFFF; load = 1'b1;
    step();
    load = 1'b0;
    repeat (9) step();
    check("pre_rst_an", 32'(an), 32'h0000000b);
    rst = 1'b1; load = 1'b1; value = 16'h4321;
    step();
    check("rst_seg", 32'(seg), 32'h0000007f);
    check("rst_dp", 32'(dp), 32'h00000001);
    check("rst_an", 32'(an), 32'h0000000f);
    rst = 1'b0; load = 1'b0;
    step();
    check("rst_dead_an", 32'(an), 32'h0000000f);
    step();
    check("rst_d0_an", 32'(an), 32'h0000000e);
    check("rst_clr_seg", 32'(seg), 32'(7'b0000001));

`ifdef SEVEN_SEG_BLINK_EN
    // Blink digit 0: lit for BF frames, dark for BF frames
    do_reset();
    blink = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      on_cnt[f] = 0;
      repeat (N * RD) begin
        step();
        if (an[0] == 1'b0) on_cnt[f]++;
      end
    end
    check("blk_f0", 32'(on_cnt[0]), 32'(RD - DC));
    check("blk_f1", 32'(on_cnt[1]), 32'(RD - DC));
    check("blk_f2", 32'(on_cnt[2]), 32'd0);
    check("blk_f3", 32'(on_cnt[3]), 32'd0);
`else
    on_cnt[0] = 0;
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom % 8) == 0;
      lz_blank = 1'($urandom);
      rst      = ($urandom % 150) == 0;
      if (($urandom % 4) == 0) value = value & 16'h00FF;
      if (($urandom % 4) == 0) value = value & 16'h000F;
`ifdef SEVEN_SEG_BLINK_EN
      if (($urandom % 64) == 0) blink = 4'($urandom);
`endif
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
